fetch_stage: RTL and testbench



---
 rtl/arm_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 59 +++++
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared constants for the ARM pipeline front end.
//   ADDR_W           : default PC / instruction-memory address width
//   INSTR_W          : default instruction word width
//   RESET_PC_DEFAULT : default PC loaded on reset (word aligned)
//   NOP_INSTR        : all-zero word placed in IF/ID when a bubble is inserted
//   wordAlign()      : clears the two byte-offset bits of an address
// ---------------------------------------------------------------------------
package arm_pkg;

   localparam int          ADDR_W           = 32;
   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
   localparam logic [31:0] NOP_INSTR        = 32'b0;

   // Branch targets come from the EXE stage and may carry stray byte-offset
   // bits; instruction fetch is always word aligned, so those bits are dropped.
   function automatic logic [31:0] wordAlign(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register: captures PC+4 and the fetched instruction word.
// Ports:
//   clk        in  rising-edge clock
//   rst        in  synchronous active-high reset, clears all contents
//   freeze     in  hazard stall, holds current contents
//   flush      in  kill current fetch, loads a bubble (beats freeze)
//   pc_in      in  PC+4 of the word being fetched
//   instr_in   in  word returned by instruction memory
//   pc_out     out registered PC+4 for ID
//   instr_out  out registered instruction for ID
//   valid_out  out 1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_id_reg
   import arm_pkg::*;
#(
   parameter int AW = 32,
   parameter int IW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          flush,
   input  logic [AW-1:0] pc_in,
   input  logic [IW-1:0] instr_in,
   output logic [AW-1:0] pc_out,
   output logic [IW-1:0] instr_out,
   output logic          valid_out
);

   logic [AW-1:0] pc_q;
   logic [IW-1:0] instr_q;
   logic          valid_q;

   // A flush always produces a bubble, even during a stall, so a killed
   // wrong-path instruction can never stay parked in ID. With neither flush
   // nor freeze the register simply takes the current fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= IW'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (flush) begin
         pc_q    <= '0;
         instr_q <= IW'(NOP_INSTR);
         valid_q <= 1'b0;
      end else if (!freeze) begin
         pc_q    <= pc_in;
         instr_q <= instr_in;
         valid_q <= 1'b1;
      end
   end

   assign pc_out    = pc_q;
   assign instr_out = instr_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// ARM pipeline IF stage: program counter, PC+4 incrementer, branch redirect
// and the IF/ID pipeline register.
// Ports:
//   clk               in  rising-edge clock
//   rst               in  synchronous active-high reset
//   freeze            in  hazard stall: hold PC and IF/ID
//   branch_taken      in  EXE taken branch: redirect PC, kill IF/ID
//   branch_addr       in  branch target from EXE
//   flush             in  kill IF/ID without redirecting the PC
//   imem_addr         out instruction memory address (= PC, combinational)
//   imem_instruction  in  word returned by memory in the same cycle
//   pc_id             out registered PC+4 of the instruction in ID
//   instruction_id    out registered instruction for ID
//   valid_id          out 1 = real fetch, 0 = bubble
// ---------------------------------------------------------------------------
module fetch_stage
   import arm_pkg::*;
#(
   parameter int                 ADDR_W   = arm_pkg::ADDR_W,
   parameter int                 INSTR_W  = arm_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(arm_pkg::RESET_PC_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   input  logic               flush,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instruction,
   output logic [ADDR_W-1:0]  pc_id,
   output logic [INSTR_W-1:0] instruction_id,
   output logic               valid_id
);

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pcPlus4;
   logic [ADDR_W-1:0] branchTarget;
   logic              killFetch;

   // The incrementer wraps naturally at the top of the address space, so
   // the last word fetches address zero next with no special handling.
   assign pcPlus4      = pc_q + ADDR_W'(4);
   assign branchTarget = {branch_addr[ADDR_W-1:2], 2'b00};
   assign killFetch    = branch_taken | flush;

   // Next-PC selection: a resolved taken branch overrides a stall because
   // the stalled instruction is on the wrong path anyway.
   always_comb begin
      pc_d = pcPlus4;
      if (branch_taken) begin
         pc_d = branchTarget;
      end else if (freeze) begin
         pc_d = pc_q;
      end
   end

   // Program counter register; reset discards any pending branch or stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Memory is zero latency, so the PC goes straight out as the address.
   assign imem_addr = pc_q;

   // IF/ID register: a taken branch kills the instruction fetched this
   // cycle, giving exactly one bubble per branch.
   if_id_reg #(
      .AW (ADDR_W),
      .IW (INSTR_W)
   ) u_if_id_reg (
      .clk       (clk),
      .rst       (rst),
      .freeze    (freeze),
      .flush     (killFetch),
      .pc_in     (pcPlus4),
      .instr_in  (imem_instruction),
      .pc_out    (pc_id),
      .instr_out (instruction_id),
      .valid_out (valid_id)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage: a directed vector table, a hand-written sequence of
// back-to-back branches, then randomized stimulus compared against a
// behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'd0;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branchTaken;
   logic [31:0] branchAddr;
   logic        flush;
   logic [31:0] imemAddr;
   logic [31:0] imemInstruction;
   logic [31:0] pcId;
   logic [31:0] instructionId;
   logic        validId;

   int vectors;
   int miscompares;

   // Behavioural model state: what the PC and ID stage should hold.
   logic [31:0] mPc;
   logic [31:0] mIdPc;
   logic [31:0] mIdInstr;
   logic        mIdValid;

   typedef struct {
      logic        rst;
      logic        freeze;
      logic        branch;
      logic [31:0] baddr;
      logic        flush;
      logic [31:0] expAddr;
      logic [31:0] expPcId;
      logic [31:0] expInstr;
      logic        expValid;
   } vec_t;

   vec_t table_q[$];

   fetch_stage #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .freeze           (freeze),
      .branch_taken     (branchTaken),
      .branch_addr      (branchAddr),
      .flush            (flush),
      .imem_addr        (imemAddr),
      .imem_instruction (imemInstruction),
      .pc_id            (pcId),
      .instruction_id   (instructionId),
      .valid_id         (validId)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory contents: a recognisable pattern derived from the
   // address, with a window of zero words to check zero passthrough.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a >= 32'h200 && a < 32'h300) begin
         return 32'h0;
      end
      return a ^ 32'hE000_0000;
   endfunction

   assign imemInstruction = memWord(imemAddr);

   // Drives one cycle of inputs, waits for the edge, advances the model by
   // the stage's rules and leaves time 1 unit past the edge for sampling.
   task automatic applyStimulus(input logic r, input logic frz, input logic br,
                                input logic [31:0] ba, input logic fl);
      logic [31:0] fetched;
      logic [31:0] seq;
      rst         = r;
      freeze      = frz;
      branchTaken = br;
      branchAddr  = ba;
      flush       = fl;
      @(posedge clk);
      if (r) begin
         mPc      = RESET_PC;
         mIdPc    = 32'h0;
         mIdInstr = 32'h0;
         mIdValid = 1'b0;
      end else begin
         fetched = memWord(mPc);
         seq     = mPc + 32'd4;
         if (br || fl) begin
            mIdPc    = 32'h0;
            mIdInstr = 32'h0;
            mIdValid = 1'b0;
         end else if (!frz) begin
            mIdPc    = seq;
            mIdInstr = fetched;
            mIdValid = 1'b1;
         end
         if (br) begin
            mPc = ba & ~32'd3;
         end else if (!frz) begin
            mPc = seq;
         end
      end
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] expAddr,
                              input logic [31:0] expPcId, input logic [31:0] expInstr,
                              input logic expValid);
      vectors++;
      if (imemAddr !== expAddr) begin
         miscompares++;
         $display("[TB] FAIL %s imem_addr got %h want %h", name, imemAddr, expAddr);
      end
      vectors++;
      if (pcId !== expPcId) begin
         miscompares++;
         $display("[TB] FAIL %s pc_id got %h want %h", name, pcId, expPcId);
      end
      vectors++;
      if (instructionId !== expInstr) begin
         miscompares++;
         $display("[TB] FAIL %s instruction_id got %h want %h", name, instructionId, expInstr);
      end
      vectors++;
      if (validId !== expValid) begin
         miscompares++;
         $display("[TB] FAIL %s valid_id got %b want %b", name, validId, expValid);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic frz, input logic br,
                               input logic [31:0] ba, input logic fl,
                               input logic [31:0] ea, input logic [31:0] ep,
                               input logic [31:0] ei, input logic ev);
      vec_t v;
      v.rst = r; v.freeze = frz; v.branch = br; v.baddr = ba; v.flush = fl;
      v.expAddr = ea; v.expPcId = ep; v.expInstr = ei; v.expValid = ev;
      return v;
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      freeze      = 1'b0;
      branchTaken = 1'b0;
      branchAddr  = 32'h0;
      flush       = 1'b0;

      //                 rst frz br  baddr          fl   addr           pc_id          instr          v
      table_q.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         0));
      table_q.push_back(mk(1, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h4,         32'h4,         32'hE000_0000, 1));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h8,         32'h8,         32'hE000_0004, 1));
      table_q.push_back(mk(0, 1, 0, 32'h0,         0, 32'h8,         32'h8,         32'hE000_0004, 1));
      table_q.push_back(mk(0, 1, 0, 32'h0,         0, 32'h8,         32'h8,         32'hE000_0004, 1));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'hC,         32'hC,         32'hE000_0008, 1));
      table_q.push_back(mk(0, 0, 1, 32'h90,        0, 32'h90,        32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h94,        32'h94,        32'hE000_0090, 1));
      table_q.push_back(mk(0, 0, 1, 32'h70,        0, 32'h70,        32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h74,        32'h74,        32'hE000_0070, 1));
      table_q.push_back(mk(0, 1, 1, 32'h9E,        0, 32'h9C,        32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'hA0,        32'hA0,        32'hE000_009C, 1));
      table_q.push_back(mk(0, 1, 0, 32'h0,         1, 32'hA0,        32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         1, 32'hA4,        32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'hA8,        32'hA8,        32'hE000_00A4, 1));
      table_q.push_back(mk(0, 0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         32'h1FFF_FFFC, 1));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h4,         32'h4,         32'hE000_0000, 1));
      table_q.push_back(mk(0, 0, 1, 32'h200,       0, 32'h200,       32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h204,       32'h204,       32'h0,         1));
      table_q.push_back(mk(1, 1, 1, 32'h500,       0, 32'h0,         32'h0,         32'h0,         0));
      table_q.push_back(mk(0, 0, 0, 32'h0,         0, 32'h4,         32'h4,         32'hE000_0000, 1));

      for (int i = 0; i < table_q.size(); i++) begin
         applyStimulus(table_q[i].rst, table_q[i].freeze, table_q[i].branch,
                       table_q[i].baddr, table_q[i].flush);
         checkOutput($sformatf("table[%0d]", i), table_q[i].expAddr,
                     table_q[i].expPcId, table_q[i].expInstr, table_q[i].expValid);
      end

      // Back-to-back taken branches: each inserts its own bubble and only
      // the second target is fetched.
      applyStimulus(0, 0, 1, 32'h40, 0);
      checkOutput("b2b_first", 32'h40, 32'h0, 32'h0, 1'b0);
      applyStimulus(0, 0, 1, 32'h180, 0);
      checkOutput("b2b_second", 32'h180, 32'h0, 32'h0, 1'b0);
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("b2b_target", 32'h184, 32'h184, 32'hE000_0180, 1'b1);

      // Randomized traffic against the behavioural model.
      for (int n = 0; n < 400; n++) begin
         logic        r;
         logic        frz;
         logic        br;
         logic        fl;
         logic [31:0] ba;
         r   = ($urandom_range(0, 99) == 0);
         frz = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 7) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       ba = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            1:       ba = 32'h200 + 32'($urandom_range(0, 255));
            default: ba = $urandom;
         endcase
         applyStimulus(r, frz, br, ba, fl);
         checkOutput($sformatf("rand[%0d]", n), mPc, mIdPc, mIdInstr, mIdValid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
